riscv_dual_port_mem: RTL and testbench

Synthesizable, parametrised instruction and data memory for the RISC-V core. It replaces the ad-hoc array memories in the processor bench.
- Instruction port: one-cycle registered fetch.
- Data port: request/ready handshake, per-byte write masking, programmable wait states, alignment and range error reporting.
- Sits between the core's iaddr/instr and dm_* interface and a single shared word array.

---
 rtl/riscv_dual_port_mem_if.sv | 28 ++
 rtl/riscv_dual_port_mem.sv | 116 +++++++++++
 tb/tb_riscv_dual_port_mem.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_dual_port_mem_if.sv
// Core-facing bus of the shared memory: registered fetch port plus the data
// request/response handshake.
interface riscv_dual_port_mem_if #(
   parameter int DATA_W = 32
);
   localparam int NB = DATA_W / 8;

   logic [31:0]       iaddr;
   logic [DATA_W-1:0] instr;
   logic              dm_req;
   logic              dm_wr_req;
   logic [31:0]       dm_addr;
   logic [DATA_W-1:0] dm_data_in;
   logic [NB-1:0]     dm_wr_mask;
   logic [DATA_W-1:0] dm_data_o;
   logic              dm_ready;
   logic              dm_err;

   modport master (
      output iaddr, dm_req, dm_wr_req, dm_addr, dm_data_in, dm_wr_mask,
      input  instr, dm_data_o, dm_ready, dm_err
   );

   modport slave (
      input  iaddr, dm_req, dm_wr_req, dm_addr, dm_data_in, dm_wr_mask,
      output instr, dm_data_o, dm_ready, dm_err
   );
endinterface

// File: rtl/riscv_dual_port_mem.sv
// Shared instruction/data word memory: one-cycle fetch port and a data port with
// byte-masked writes, programmable wait states and alignment/range errors.
//
//   state  | meaning
//   S_IDLE | no access outstanding, dm_req accepted
//   S_WAIT | access latched, counting down wait states
//   S_RESP | dm_ready/dm_err strobe cycle, dm_req accepted
module riscv_dual_port_mem #(
   parameter int    DATA_W      = 32,
   parameter int    MEM_DEPTH   = 256,
   parameter int    WAIT_STATES = 0,
   parameter string INIT_FILE   = ""
) (
   input  logic                 clk,
   input  logic                 rst,
   riscv_dual_port_mem_if.slave bus
);
   localparam int NB    = DATA_W / 8;
   localparam int OFF   = $clog2(NB);
   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int CNT_W = 4;
   localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              accept;
   logic              do_access;
   logic              mem_we;
   logic [31:0]       addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [NB-1:0]     mask_q;
   logic              wr_q;
   logic [DATA_W-1:0] mem [MEM_DEPTH];

   function automatic logic addr_ok(input logic [31:0] a);
      return ((a & 32'(NB - 1)) == 32'd0) && ((a >> OFF) < 32'(MEM_DEPTH));
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
      return IDX_W'(a >> OFF);
   endfunction

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      do_access = 1'b0;
      unique case (state)
         S_IDLE, S_RESP: begin
            state_nxt = S_IDLE;
            if (bus.dm_req) begin
               accept    = 1'b1;
               state_nxt = S_WAIT;
               cnt_nxt   = CNT_W'(WAIT_STATES);
            end
         end
         S_WAIT: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else begin
               do_access = 1'b1;
               state_nxt = S_RESP;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign mem_we = do_access && wr_q && addr_ok(addr_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         cnt           <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         mask_q        <= '0;
         wr_q          <= 1'b0;
         bus.dm_data_o <= '0;
         bus.dm_ready  <= 1'b0;
         bus.dm_err    <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         bus.dm_ready <= do_access;
         if (accept) begin
            addr_q  <= bus.dm_addr;
            wdata_q <= bus.dm_data_in;
            mask_q  <= bus.dm_wr_mask;
            wr_q    <= bus.dm_wr_req;
         end
         if (do_access) begin
            bus.dm_err    <= !addr_ok(addr_q);
            bus.dm_data_o <= (!wr_q && addr_ok(addr_q)) ? mem[word_idx(addr_q)] : '0;
         end else begin
            bus.dm_err <= 1'b0;
         end
      end
   end

   // Nonblocking write keeps a same-edge fetch of this word on the old value.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < NB; b++) begin
            if (mask_q[b]) mem[word_idx(addr_q)][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) bus.instr <= NOP;
      else      bus.instr <= addr_ok(bus.iaddr) ? mem[word_idx(bus.iaddr)] : NOP;
   end
endmodule

// File: tb/tb_riscv_dual_port_mem.sv
// Three memories (0, 3 and 5 wait states) driven by directed and random traffic,
// checked every cycle against a cycle-numbered reference model.
module tb_riscv_dual_port_mem;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic [2:0]  rst_v, req, wr, ready, err;
   logic [31:0] addr [3];
   logic [31:0] wdata [3];
   logic [3:0]  mask [3];
   logic [31:0] iaddr [3];
   logic [31:0] rdata [3];
   logic [31:0] instr [3];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int WSG = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
      riscv_dual_port_mem_if #(.DATA_W(32)) bus ();
      assign bus.iaddr      = iaddr[g];
      assign bus.dm_req     = req[g];
      assign bus.dm_wr_req  = wr[g];
      assign bus.dm_addr    = addr[g];
      assign bus.dm_data_in = wdata[g];
      assign bus.dm_wr_mask = mask[g];
      assign instr[g]       = bus.instr;
      assign rdata[g]       = bus.dm_data_o;
      assign ready[g]       = bus.dm_ready;
      assign err[g]         = bus.dm_err;
      riscv_dual_port_mem #(.DATA_W(32), .MEM_DEPTH(256), .WAIT_STATES(WSG), .INIT_FILE(""))
         u_dut (.clk(clk), .rst(rst_v[g]), .bus(bus));
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // reference model state
   logic [31:0] mm [3][256];
   bit          mv [3][256];
   bit          pend [3];
   int          resp_at [3];
   int          free_at [3];
   bit          p_wr [3];
   logic [31:0] p_addr [3];
   logic [31:0] p_data [3];
   logic [3:0]  p_mask [3];
   bit          e_ready [3];
   bit          e_err [3];
   bit          e_dknown [3];
   bit          e_iknown [3];
   logic [31:0] e_data [3];
   logic [31:0] e_instr [3];

   function automatic int ws_of(input int k);
      return (k == 0) ? 0 : ((k == 1) ? 3 : 5);
   endfunction

   function automatic bit in_range(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a[31:2] < 30'd256);
   endfunction

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[dut%0d] cycle %0d: got %h, expected %h", name, k, cyc, act, exp);
      end
   endtask

   task automatic model_clear(input int k);
      pend[k]     = 1'b0;
      free_at[k]  = 0;
      e_ready[k]  = 1'b0;
      e_err[k]    = 1'b0;
      e_data[k]   = '0;
      e_dknown[k] = 1'b1;
      e_instr[k]  = NOP;
      e_iknown[k] = 1'b1;
   endtask

   task automatic model_step(input int k);
      int wi;
      if (!in_range(iaddr[k])) begin
         e_instr[k]  = NOP;
         e_iknown[k] = 1'b1;
      end else begin
         wi          = int'(iaddr[k][31:2]);
         e_instr[k]  = mm[k][wi];
         e_iknown[k] = mv[k][wi];
      end
      e_ready[k] = 1'b0;
      e_err[k]   = 1'b0;
      if (pend[k] && resp_at[k] == cyc) begin
         pend[k]     = 1'b0;
         e_ready[k]  = 1'b1;
         e_data[k]   = '0;
         e_dknown[k] = 1'b1;
         if (!in_range(p_addr[k])) begin
            e_err[k] = 1'b1;
         end else begin
            wi = int'(p_addr[k][31:2]);
            if (p_wr[k]) begin
               for (int b = 0; b < 4; b++)
                  if (p_mask[k][b]) mm[k][wi][8*b +: 8] = p_data[k][8*b +: 8];
               if (p_mask[k] == 4'hF) mv[k][wi] = 1'b1;
            end else begin
               e_data[k]   = mm[k][wi];
               e_dknown[k] = mv[k][wi];
            end
         end
      end
      if (req[k] === 1'b1 && cyc >= free_at[k]) begin
         pend[k]    = 1'b1;
         resp_at[k] = cyc + 1 + ws_of(k);
         free_at[k] = cyc + 2 + ws_of(k);
         p_wr[k]    = wr[k];
         p_addr[k]  = addr[k];
         p_data[k]  = wdata[k];
         p_mask[k]  = mask[k];
      end
   endtask

   initial begin
      cyc = 0;
      for (int k = 0; k < 3; k++) model_clear(k);
      forever begin
         @(posedge clk);
         cyc++;
         for (int k = 0; k < 3; k++) begin
            if (rst_v[k] !== 1'b1) model_clear(k);
            else                   model_step(k);
         end
      end
   end

   // compare process
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (rst_v[k] !== 1'b1) begin
               chk("rst_ready", k, 32'(ready[k]), 32'd0);
               chk("rst_err",   k, 32'(err[k]),   32'd0);
               chk("rst_data",  k, rdata[k],      32'd0);
               chk("rst_instr", k, instr[k],      NOP);
            end else begin
               chk("ready", k, 32'(ready[k]), 32'(e_ready[k]));
               chk("err",   k, 32'(err[k]),   32'(e_err[k]));
               if (e_ready[k] && e_dknown[k]) chk("data", k, rdata[k], e_data[k]);
               if (e_iknown[k]) chk("instr", k, instr[k], e_instr[k]);
            end
         end
      end
   end

   task automatic access(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, output logic [31:0] rd, output bit e, output int lat);
      int  t0;
      bit  seen;
      rd   = '0;
      e    = 1'b0;
      lat  = -1;
      seen = 1'b0;
      @(posedge clk); #2;
      req[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d; mask[k] = m;
      @(posedge clk); #2;
      t0 = cyc;
      req[k] = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (ready[k] === 1'b1) begin
            seen = 1'b1;
            lat  = cyc - t0;
            rd   = rdata[k];
            e    = err[k];
         end
      end
      if (!seen) chk("resp_timeout", k, 32'd0, 32'd1);
   endtask

   task automatic read_sum(input int k, output logic [31:0] s);
      logic [31:0] rd;
      bit          e;
      int          lat;
      s = '0;
      for (int i = 0; i < 256; i++) begin
         access(k, 1'b0, 32'(4 * i), 32'd0, 4'h0, rd, e, lat);
         s = s + rd;
      end
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, old, s0, s1, ms;
      bit          e;
      int          lat, pulses, sel;
      bit          r1, r2, r3;
      logic [31:0] d1;

      rst_v = 3'b000; req = 3'b000; wr = 3'b000;
      for (int k = 0; k < 3; k++) begin
         addr[k] = '0; wdata[k] = '0; mask[k] = '0; iaddr[k] = '0;
      end
      repeat (2) @(posedge clk);
      #2 rst_v = 3'b111;
      @(negedge clk);
      chk("reset_instr", 0, instr[0], 32'h0000_0013);
      chk("reset_ready", 0, 32'(ready[0]), 32'd0);
      chk("reset_data",  0, rdata[0], 32'd0);
      chk("reset_err",   0, 32'(err[0]), 32'd0);

      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 256; i++)
            access(k, 1'b1, 32'(4 * i), $urandom, 4'hF, rd, e, lat);

      // fetch port picks up a freshly written word one edge after iaddr points at it
      iaddr[0] = 32'd4;
      access(0, 1'b1, 32'd0, 32'h0025_8513, 4'hF, rd, e, lat);
      @(posedge clk); #2;
      iaddr[0] = 32'd0;
      @(negedge clk);
      @(negedge clk);
      chk("fetch_mem0", 0, instr[0], 32'h0025_8513);

      access(0, 1'b1, 32'd8, 32'h1122_3344, 4'hF, rd, e, lat);
      access(0, 1'b1, 32'd8, 32'hAABB_CCDD, 4'b0101, rd, e, lat);
      chk("mwr_latency", 0, 32'(lat), 32'd1);
      chk("mwr_err",     0, 32'(e),   32'd0);
      chk("mwr_data",    0, rd,       32'd0);
      access(0, 1'b0, 32'd8, 32'd0, 4'h0, rd, e, lat);
      chk("mwr_readback", 0, rd, 32'h11BB_33DD);
      access(0, 1'b1, 32'd8, 32'hFFFF_FFFF, 4'h0, rd, e, lat);
      chk("mask0_err", 0, 32'(e), 32'd0);
      access(0, 1'b0, 32'd8, 32'd0, 4'hF, rd, e, lat);
      chk("mask0_readback", 0, rd, 32'h11BB_33DD);

      // back-to-back: requests sampled at N and N+2
      @(posedge clk); #2;
      req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'd8; mask[0] = 4'h0;
      @(posedge clk); #2;
      req[0] = 1'b0;
      @(posedge clk); #2;
      req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'd12; wdata[0] = 32'hCAFE_F00D; mask[0] = 4'hF;
      @(negedge clk);
      r1 = ready[0]; d1 = rdata[0];
      @(posedge clk); #2;
      req[0] = 1'b0;
      @(negedge clk);
      r2 = ready[0];
      @(negedge clk);
      r3 = ready[0];
      chk("b2b_ready_n1", 0, 32'(r1), 32'd1);
      chk("b2b_data_n1",  0, d1,      32'h11BB_33DD);
      chk("b2b_ready_n2", 0, 32'(r2), 32'd0);
      chk("b2b_ready_n3", 0, 32'(r3), 32'd1);
      access(0, 1'b0, 32'd12, 32'd0, 4'h0, rd, e, lat);
      chk("b2b_readback", 0, rd, 32'hCAFE_F00D);

      // three wait states; the write sampled at N+2 must be ignored
      old = mm[1][1];
      @(posedge clk); #2;
      req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'd4; mask[1] = 4'h0;
      @(posedge clk); #2;
      lat = cyc;
      req[1] = 1'b0;
      @(posedge clk); #2;
      req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'd4; wdata[1] = ~old; mask[1] = 4'hF;
      @(posedge clk); #2;
      req[1] = 1'b0;
      pulses = 0; sel = -1; d1 = '0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ready[1] === 1'b1) begin
            if (pulses == 0) begin sel = cyc - lat; d1 = rdata[1]; end
            pulses++;
         end
      end
      chk("ws3_pulses",  1, 32'(pulses), 32'd1);
      chk("ws3_latency", 1, 32'(sel),    32'd4);
      chk("ws3_data",    1, d1,          old);
      access(1, 1'b0, 32'd4, 32'd0, 4'h0, rd, e, lat);
      chk("ws3_ignored_write", 1, rd, old);

      // errors and whole-array checksum
      access(0, 1'b0, 32'd6, 32'd0, 4'h0, rd, e, lat);
      chk("misalign_err",  0, 32'(e), 32'd1);
      chk("misalign_data", 0, rd,     32'd0);
      read_sum(0, s0);
      ms = '0;
      for (int i = 0; i < 256; i++) ms = ms + mm[0][i];
      chk("checksum_model", 0, s0, ms);
      access(0, 1'b1, 32'd1024, 32'hFFFF_FFFF, 4'hF, rd, e, lat);
      chk("range_err",  0, 32'(e), 32'd1);
      chk("range_data", 0, rd,     32'd0);
      read_sum(0, s1);
      chk("checksum_after_err", 0, s1, s0);

      // reset two cycles into a five-wait-state write
      old = mm[2][3];
      @(posedge clk); #2;
      req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'd12; wdata[2] = ~old; mask[2] = 4'hF;
      @(posedge clk); #2;
      req[2] = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      rst_v[2] = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_v[2] = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ready[2] === 1'b1) pulses++;
      end
      chk("rst_mid_pulses", 2, 32'(pulses), 32'd0);
      access(2, 1'b0, 32'd12, 32'd0, 4'h0, rd, e, lat);
      chk("rst_mid_mem3", 2, rd, old);

      // free-running random traffic, including requests while busy and fetch collisions
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #2;
         for (int k = 0; k < 3; k++) begin
            req[k]   = ($urandom_range(0, 2) == 0);
            wr[k]    = 1'($urandom_range(0, 1));
            wdata[k] = $urandom;
            mask[k]  = 4'($urandom_range(0, 15));
            sel      = int'($urandom_range(0, 9));
            if (sel < 8)       addr[k] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            else if (sel == 8) addr[k] = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
            else               addr[k] = 32'd1024 + 32'(4 * $urandom_range(0, 1000));
            sel      = int'($urandom_range(0, 9));
            if (sel < 8)       iaddr[k] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            else if (sel == 8) iaddr[k] = 32'd2;
            else               iaddr[k] = 32'h0000_0800;
         end
      end
      @(posedge clk); #2;
      req = 3'b000;
      repeat (20) @(posedge clk);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
